// File: rtl/serial_addsub_ctrl_if.sv
// Request/result bundle between a requester and the serial add/sub sequencer.
// The requester (master) drives start and operands; the sequencer (slave)
// returns handshake status, the registered result and its flags.
interface serial_addsub_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         addsub;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] F;
    logic         cf;
    logic         zero;
    logic         of;

    modport master (
        output start, A, B, addsub,
        input  ready, busy, done, F, cf, zero, of
    );

    modport slave (
        input  start, A, B, addsub,
        output ready, busy, done, F, cf, zero, of
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Serial wide add/subtract: one 4-bit add/sub slice is reused for NIBBLES
// cycles, least-significant nibble first, with the carry held in a register.
// Flags (cf, zero, of) describe the full-width result.
// Optional feature: define SERIAL_ADDSUB_SAT_EN to clamp the result to the
// signed limit on overflow instead of wrapping (cf/of stay unsaturated).
module serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_addsub_ctrl_if.slave bus
);
    localparam int         W    = 4 * NIBBLES;
    localparam logic [2:0] LAST = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [W-1:0] a_q;       // latched A, shifted down one nibble per RUN cycle
    logic [W-1:0] b_q;       // latched B, shifted the same way
    logic [W-1:0] res_q;     // result nibbles written so far
    logic         sub_q;
    logic         c_q;
    logic [2:0]   idx_q;

    logic         ready_q;
    logic         busy_q;
    logic         done_q;
    logic [W-1:0] f_q;
    logic         cf_q;
    logic         zero_q;
    logic         of_q;

    logic [3:0]   a_nib;
    logic [3:0]   b_nib;
    logic [4:0]   sum;
    logic [4:0]   sh_amt;
    logic [W-1:0] nib_mask;
    logic [W-1:0] nib_ins;
    logic [W-1:0] res_next;
    logic [W-1:0] f_next;
    logic         of_raw;

`ifdef SERIAL_ADDSUB_SAT_EN
    // Clamp toward the sign of A when the signed result overflowed.
    function automatic logic signed [W-1:0] sat_clamp(
        input logic signed [W-1:0] raw,
        input logic                ovf,
        input logic                a_msb
    );
        if (!ovf)
            return raw;
        else if (a_msb)
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction
`endif

    // One slice of add/sub for the current nibble, plus the merged result.
    always_comb begin
        a_nib    = a_q[3:0];
        b_nib    = b_q[3:0] ^ {4{sub_q}};
        sum      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_q};
        sh_amt   = {idx_q, 2'b00};
        nib_mask = W'(4'hF) << sh_amt;
        nib_ins  = W'(sum[3:0]) << sh_amt;
        res_next = (res_q & ~nib_mask) | nib_ins;
        // Carry into the MSB recovered from the sum bit; XOR with carry out.
        of_raw   = (a_nib[3] ^ b_nib[3] ^ sum[3]) ^ sum[4];
`ifdef SERIAL_ADDSUB_SAT_EN
        f_next   = sat_clamp(res_next, of_raw, a_nib[3]);
`else
        f_next   = res_next;
`endif
    end

    // Sequencer FSM with registered handshake, result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            c_q     <= 1'b0;
            idx_q   <= 3'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            f_q     <= '0;
            cf_q    <= 1'b0;
            zero_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        sub_q   <= bus.addsub;
                        c_q     <= bus.addsub;
                        idx_q   <= 3'd0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_next;
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    c_q   <= sum[4];
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == LAST) begin
                        f_q    <= f_next;
                        cf_q   <= sum[4] ^ sub_q;
                        of_q   <= of_raw;
                        zero_q <= (f_next == '0);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.F     = f_q;
    assign bus.cf    = cf_q;
    assign bus.zero  = zero_q;
    assign bus.of    = of_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl with NIBBLES=4 (16-bit operands).
module tb_serial_addsub_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_addsub_ctrl_if #(.NIBBLES(4)) bus ();

    serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [15:0] F_OVF_ADD = 16'h7FFF;
    localparam logic [15:0] F_OVF_SUB = 16'h8000;
`else
    localparam logic [15:0] F_OVF_ADD = 16'h8000;
    localparam logic [15:0] F_OVF_SUB = 16'h7FFF;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and check the full handshake timeline.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] ef, input logic ecf,
                          input logic ez, input logic eof);
        bus.start  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.addsub = sub;
        step();
        bus.start  = 1'b0;
        bus.A      = 16'hDEAD;
        bus.B      = 16'hBEEF;
        bus.addsub = ~sub;
        chk1({tag, ".busy_acc"}, bus.busy, 1'b1);
        chk1({tag, ".ready_acc"}, bus.ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1({tag, ".done_run"}, bus.done, 1'b0);
            chk1({tag, ".busy_run"}, bus.busy, 1'b1);
        end
        step();
        chk1({tag, ".done"}, bus.done, 1'b1);
        chk1({tag, ".busy_done"}, bus.busy, 1'b0);
        chk({tag, ".F"}, bus.F, ef);
        chk1({tag, ".cf"}, bus.cf, ecf);
        chk1({tag, ".zero"}, bus.zero, ez);
        chk1({tag, ".of"}, bus.of, eof);
        step();
        chk1({tag, ".done_clr"}, bus.done, 1'b0);
        chk1({tag, ".ready_ret"}, bus.ready, 1'b1);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.A      = 16'h0000;
        bus.B      = 16'h0000;
        bus.addsub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Asynchronous reset pulse while idle, between clock edges.
        #2 rst = 1'b1;
        #1;
        chk1("rst.ready", bus.ready, 1'b1);
        chk1("rst.busy", bus.busy, 1'b0);
        chk1("rst.done", bus.done, 1'b0);
        chk("rst.F", bus.F, 16'h0000);
        chk1("rst.cf", bus.cf, 1'b0);
        chk1("rst.zero", bus.zero, 1'b0);
        chk1("rst.of", bus.of, 1'b0);
        #1 rst = 1'b0;
        step();

        run_op("add_ovf", 16'h0001, 16'h7FFF, 1'b0, F_OVF_ADD, 1'b0, 1'b0, 1'b1);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, F_OVF_SUB, 1'b0, 1'b0, 1'b1);

        // start held high: the next accept is two edges after the done edge.
        bus.start  = 1'b1;
        bus.A      = 16'h0102;
        bus.B      = 16'h0203;
        bus.addsub = 1'b0;
        step();
        chk1("hs.acc1", bus.busy, 1'b1);
        bus.A = 16'hFFFF;
        bus.B = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("hs.run1_done", bus.done, 1'b0);
        end
        step();
        chk1("hs.done1", bus.done, 1'b1);
        chk("hs.F1", bus.F, 16'h0305);
        bus.A = 16'h1000;
        bus.B = 16'h0001;
        step();
        chk1("hs.no_acc_in_done", bus.busy, 1'b0);
        chk1("hs.ready", bus.ready, 1'b1);
        chk("hs.F1_hold", bus.F, 16'h0305);
        step();
        chk1("hs.acc2", bus.busy, 1'b1);
        bus.A = 16'hAAAA;
        bus.B = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hs.F1_stable", bus.F, 16'h0305);
            chk1("hs.run2_done", bus.done, 1'b0);
        end
        step();
        bus.start = 1'b0;
        chk1("hs.done2", bus.done, 1'b1);
        chk("hs.F2", bus.F, 16'h1001);
        step();
        chk1("hs.ready2", bus.ready, 1'b1);

        // Reset during the second RUN cycle aborts the operation.
        bus.start  = 1'b1;
        bus.A      = 16'h1234;
        bus.B      = 16'h1111;
        bus.addsub = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk1("abort.ready", bus.ready, 1'b1);
        chk1("abort.busy", bus.busy, 1'b0);
        chk("abort.F", bus.F, 16'h0000);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("abort.no_done", bus.done, 1'b0);
        end
        run_op("after_abort", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
